// File: rtl/day_9_onehot_to_binary.sv
// Streaming one-hot to binary encoder with a single registered output stage.
// Flags malformed words (zero or several bits set) and counts them, saturating.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset_n      asynchronous active-low reset
//   one_hot_i    one-hot input word (sampled only on accept)
//   in_valid_i   input word valid
//   in_ready_o   block can accept a word this cycle
//   bin_o        encoded index (lowest set bit when malformed)
//   err_o        word held in the output register was malformed
//   out_valid_o  bin_o / err_o valid
//   out_ready_i  downstream accepts output this cycle
//   err_clr_i    synchronous clear of err_cnt_o
//   err_cnt_o    saturating count of accepted malformed words
module day_9_onehot_to_binary #(
    parameter int ONEHOT_W = 16,
    parameter int BIN_W    = 4,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ONEHOT_W-1:0] one_hot_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [BIN_W-1:0]    bin_o,
    output logic                err_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    input  logic                err_clr_i,
    output logic [ERRCNT_W-1:0] err_cnt_o
);

    localparam logic [ERRCNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERRCNT_W-1:0] CNT_ONE = ERRCNT_W'(1);
    localparam logic [ONEHOT_W-1:0] WORD_ONE = ONEHOT_W'(1);

    logic                out_valid;
    logic [BIN_W-1:0]    bin_q;
    logic                err_q;
    logic [ERRCNT_W-1:0] cnt_q;

    logic                accept;
    logic [BIN_W-1:0]    enc_bin;
    logic                enc_zero;
    logic                enc_multi;
    logic                enc_err;

    // Ready passes through from downstream so a full register can be
    // drained and refilled on the same edge; forced low during reset.
    assign in_ready_o = reset_n && (!out_valid || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    // Scan from the top so the last hit is the lowest set bit (LSB priority).
    always_comb begin
        enc_bin = '0;
        for (int i = ONEHOT_W - 1; i >= 0; i--) begin
            if (one_hot_i[i]) begin
                enc_bin = BIN_W'(i);
            end
        end
    end

    // w & (w - 1) clears the lowest set bit; anything left means >1 bit set.
    assign enc_zero  = ~|one_hot_i;
    assign enc_multi = |(one_hot_i & (one_hot_i - WORD_ONE));
    assign enc_err   = enc_zero || enc_multi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            bin_q     <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            bin_q     <= enc_bin;
            err_q     <= enc_err;
        end else if (out_ready_i) begin
            out_valid <= 1'b0;
        end
    end

    // An errored accept coinciding with a clear restarts the count at one
    // so that error is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (accept && enc_err) begin
            if (err_clr_i) begin
                cnt_q <= CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end else if (err_clr_i) begin
            cnt_q <= '0;
        end
    end

    assign out_valid_o = out_valid;
    assign bin_o       = bin_q;
    assign err_o       = err_q;
    assign err_cnt_o   = cnt_q;

endmodule

// File: tb/tb_day_9_onehot_to_binary.sv
// Randomized and directed bench for day_9_onehot_to_binary.
// Reference model: queue of expected outputs plus a saturating count.
module tb_day_9_onehot_to_binary;

    logic        clk;
    logic        reset_n;
    logic [15:0] one_hot_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  bin_o;
    logic        err_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        err_clr_i;
    logic [7:0]  err_cnt_o;

    int n_checks;
    int n_fail;

    logic [3:0] q_bin[$];
    logic       q_err[$];
    logic [7:0] m_cnt;
    logic       m_ready;
    logic       seen_ready;

    day_9_onehot_to_binary #(
        .ONEHOT_W(16),
        .BIN_W(4),
        .ERRCNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .one_hot_i(one_hot_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .bin_o(bin_o),
        .err_o(err_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .err_clr_i(err_clr_i),
        .err_cnt_o(err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_bin(input logic [15:0] w);
        logic [15:0] low;
        if (w == 16'h0) return 4'd0;
        low = w & (~w + 16'h1);
        return 4'($clog2(low));
    endfunction

    function automatic logic ref_err(input logic [15:0] w);
        return $countones(w) != 1;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge.
    task automatic step(input logic v, input logic [15:0] w,
                        input logic ordy, input logic clr);
        logic xfer;
        logic acc;
        in_valid_i  = v;
        one_hot_i   = w;
        out_ready_i = ordy;
        err_clr_i   = clr;
        #1;
        m_ready    = (q_bin.size() == 0) || ordy;
        seen_ready = in_ready_o;
        xfer = (q_bin.size() != 0) && ordy;
        acc  = v && m_ready;
        @(posedge clk);
        if (xfer) begin
            void'(q_bin.pop_front());
            void'(q_err.pop_front());
        end
        if (acc) begin
            q_bin.push_back(ref_bin(w));
            q_err.push_back(ref_err(w));
        end
        if (acc && ref_err(w)) begin
            if (clr) m_cnt = 8'd1;
            else if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end else if (clr) begin
            m_cnt = 8'd0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        in_valid_i  = 1'b0;
        one_hot_i   = '0;
        out_ready_i = 1'b0;
        err_clr_i   = 1'b0;
        m_cnt       = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || bin_o !== 4'd0 || err_o !== 1'b0 ||
            err_cnt_o !== 8'd0 || in_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: v=%b bin=%0d err=%b cnt=%0d rdy=%b, want 0 0 0 0 0",
                     out_valid_o, bin_o, err_o, err_cnt_o, in_ready_o);
        end
        reset_n = 1'b1;
        step(1'b0, 'x, 1'b1, 1'b0);
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b v=%b, want 1 0", in_ready_o, out_valid_o);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'h1 << i, 1'b1, 1'b0);
            n_checks++;
            if (out_valid_o !== 1'b1 || bin_o !== 4'(i) || err_o !== 1'b0 ||
                in_ready_o !== 1'b1 || err_cnt_o !== 8'd0) begin
                n_fail++;
                $display("FAIL sweep_%0d: v=%b bin=%0d err=%b rdy=%b cnt=%0d, want 1 %0d 0 1 0",
                         i, out_valid_o, bin_o, err_o, in_ready_o, err_cnt_o, i);
            end
        end
        step(1'b0, 'x, 1'b1, 1'b0);
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_drain: v=%b, want 0", out_valid_o);
        end
    endtask

    task automatic test_malformed();
        step(1'b1, 16'h0000, 1'b1, 1'b0);
        n_checks++;
        if (out_valid_o !== 1'b1 || bin_o !== 4'd0 || err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL malformed_zero: v=%b bin=%0d err=%b, want 1 0 1",
                     out_valid_o, bin_o, err_o);
        end
        step(1'b1, 16'h0A00, 1'b1, 1'b0);
        n_checks++;
        if (out_valid_o !== 1'b1 || bin_o !== 4'd9 || err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL malformed_multi: v=%b bin=%0d err=%b, want 1 9 1",
                     out_valid_o, bin_o, err_o);
        end
        step(1'b0, 'x, 1'b1, 1'b0);
        n_checks++;
        if (err_cnt_o !== 8'd2) begin
            n_fail++;
            $display("FAIL malformed_count: cnt=%0d, want 2", err_cnt_o);
        end
    endtask

    task automatic test_backpressure();
        step(1'b1, 16'h0010, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h0100, 1'b0, 1'b0);
            n_checks++;
            if (out_valid_o !== 1'b1 || bin_o !== 4'd4 || err_o !== 1'b0 ||
                in_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: v=%b bin=%0d err=%b rdy=%b, want 1 4 0 0",
                         i, out_valid_o, bin_o, err_o, in_ready_o);
            end
        end
        step(1'b1, 16'h0100, 1'b1, 1'b0);
        n_checks++;
        if (seen_ready !== 1'b1 || out_valid_o !== 1'b1 || bin_o !== 4'd8) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b v=%b bin=%0d, want 1 1 8",
                     seen_ready, out_valid_o, bin_o);
        end
        step(1'b0, 'x, 1'b1, 1'b0);
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: v=%b, want 0", out_valid_o);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 16'h0003, 1'b1, 1'b0);
            n_checks++;
            if (err_cnt_o !== m_cnt) begin
                n_fail++;
                $display("FAIL sat_count_%0d: cnt=%0d, want %0d", i, err_cnt_o, m_cnt);
            end
        end
        n_checks++;
        if (err_cnt_o !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_hold: cnt=%0d, want 255", err_cnt_o);
        end
        step(1'b0, 'x, 1'b1, 1'b1);
        n_checks++;
        if (err_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_clear: cnt=%0d, want 0", err_cnt_o);
        end
    endtask

    task automatic test_clear_collision();
        for (int i = 0; i < 7; i++) step(1'b1, 16'h0000, 1'b1, 1'b0);
        n_checks++;
        if (err_cnt_o !== 8'd7) begin
            n_fail++;
            $display("FAIL clr_pre: cnt=%0d, want 7", err_cnt_o);
        end
        step(1'b1, 16'h0000, 1'b1, 1'b1);
        n_checks++;
        if (err_cnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL clr_collision: cnt=%0d, want 1", err_cnt_o);
        end
        step(1'b0, 'x, 1'b1, 1'b1);
        n_checks++;
        if (err_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_after: cnt=%0d, want 0", err_cnt_o);
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [15:0] w;
        logic        ordy;
        logic        clr;
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom % 4) != 0;
            ordy = ($urandom % 3) != 0;
            clr  = ($urandom % 25) == 0;
            case ($urandom % 4)
                0:       w = 16'h0000;
                1:       w = 16'($urandom);
                default: w = 16'h1 << ($urandom % 16);
            endcase
            if (!v) w = 'x;
            step(v, w, ordy, clr);
            n_checks++;
            if (seen_ready !== m_ready) begin
                n_fail++;
                $display("FAIL rnd_ready_%0d: rdy=%b, want %b", i, seen_ready, m_ready);
            end
            n_checks++;
            if (out_valid_o !== (q_bin.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_valid_%0d: v=%b, want %b", i, out_valid_o,
                         q_bin.size() != 0);
            end else if (q_bin.size() != 0) begin
                n_checks++;
                if (bin_o !== q_bin[0] || err_o !== q_err[0]) begin
                    n_fail++;
                    $display("FAIL rnd_data_%0d: bin=%0d err=%b, want %0d %b",
                             i, bin_o, err_o, q_bin[0], q_err[0]);
                end
            end
            n_checks++;
            if (err_cnt_o !== m_cnt) begin
                n_fail++;
                $display("FAIL rnd_cnt_%0d: cnt=%0d, want %0d", i, err_cnt_o, m_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 16'h0005, 1'b0, 1'b0);
        n_checks++;
        if (out_valid_o !== 1'b1 || err_cnt_o === 8'd0) begin
            n_fail++;
            $display("FAIL rstmid_pre: v=%b cnt=%0d, want 1 nonzero",
                     out_valid_o, err_cnt_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || err_cnt_o !== 8'd0 ||
            bin_o !== 4'd0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: v=%b rdy=%b cnt=%0d bin=%0d err=%b, want 0 0 0 0 0",
                     out_valid_o, in_ready_o, err_cnt_o, bin_o, err_o);
        end
        q_bin.delete();
        q_err.delete();
        m_cnt = 8'd0;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        step(1'b0, 'x, 1'b1, 1'b0);
        n_checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_release: v=%b rdy=%b, want 0 1",
                     out_valid_o, in_ready_o);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sweep();
        test_malformed();
        test_backpressure();
        test_saturation();
        test_clear_collision();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
